// File: rtl/mcp_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : mcp_neuron_scheduler
// Brief   : Round-robin time-sharing of one serial McCulloch-Pitts neuron
//           evaluator among NREQ requesters (saturating weighted sum + fire).
// Revision: 1.0 - initial release
// ============================================================================
module mcp_neuron_scheduler #(
    parameter int NREQ = 4,
    parameter int NIN  = 4,
    parameter int WW   = 3,
    parameter int TW   = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*NIN-1:0]    x_flat,
    input  logic [NREQ*NIN*WW-1:0] w_flat,
    input  logic [NREQ*TW-1:0]     thresh_flat,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IDW-1:0]         done_id,
    output logic [TW-1:0]          sum,
    output logic                   fire
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_CMP  = 2'd2;

    localparam int               c_IXW  = (NIN > 1) ? $clog2(NIN) : 1;
    localparam logic [c_IXW-1:0] c_LAST = c_IXW'(NIN - 1);

    logic [1:0]             r_state;
    logic [IDW-1:0]         r_ptr;
    logic [IDW-1:0]         r_cur;
    logic [NIN-1:0]         r_x;
    logic [NIN*WW-1:0]      r_w;
    logic signed [TW-1:0]   r_th;
    logic signed [TW-1:0]   r_acc;
    logic [c_IXW-1:0]       r_idx;
    logic [NREQ-1:0]        r_gnt;
    logic                   r_busy;
    logic                   r_done;
    logic [IDW-1:0]         r_done_id;
    logic [TW-1:0]          r_sum;
    logic                   r_fire;

    logic [IDW-1:0]         w_win;
    logic [IDW-1:0]         w_c;
    logic                   w_any;
    logic signed [WW-1:0]   w_wsel;
    logic signed [TW:0]     w_term;
    logic signed [TW:0]     w_nsum;
    logic signed [TW-1:0]   w_sat;

    // Search starts just after the last winner so every requester gets its turn.
    always_comb begin
        w_win = '0;
        w_c   = '0;
        w_any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_c = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_any && req[w_c]) begin
                w_any = 1'b1;
                w_win = w_c;
            end
        end
    end

    // One extra bit of headroom exposes overflow, which then clamps to the rail.
    always_comb begin
        w_wsel = r_w[r_idx*WW +: WW];
        w_term = r_x[r_idx] ? (TW+1)'(w_wsel) : '0;
        w_nsum = (TW+1)'(r_acc) + w_term;
        if (w_nsum[TW] != w_nsum[TW-1])
            w_sat = w_nsum[TW] ? {1'b1, {(TW-1){1'b0}}} : {1'b0, {(TW-1){1'b1}}};
        else
            w_sat = w_nsum[TW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_ptr     <= IDW'(NREQ - 1);
            r_cur     <= '0;
            r_x       <= '0;
            r_w       <= '0;
            r_th      <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_sum     <= '0;
            r_fire    <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_ptr   <= w_win;
                        r_cur   <= w_win;
                        r_x     <= x_flat[w_win*NIN +: NIN];
                        r_w     <= w_flat[w_win*NIN*WW +: NIN*WW];
                        r_th    <= thresh_flat[w_win*TW +: TW];
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ACC;
                    end
                end
                c_ACC: begin
                    r_acc <= w_sat;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST)
                        r_state <= c_CMP;
                end
                c_CMP: begin
                    r_sum     <= r_acc;
                    r_fire    <= (r_acc >= r_th);
                    r_done    <= 1'b1;
                    r_done_id <= r_cur;
                    r_busy    <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign sum     = r_sum;
    assign fire    = r_fire;

endmodule
`default_nettype wire

// File: tb/tb_mcp_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_mcp_neuron_scheduler
// Brief   : Table-driven and randomized self-checking bench for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mcp_neuron_scheduler;

    localparam int NREQ = 4;
    localparam int NIN  = 4;
    localparam int WW   = 3;
    localparam int TW   = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*NIN-1:0]    x_flat;
    logic [NREQ*NIN*WW-1:0] w_flat;
    logic [NREQ*TW-1:0]     thresh_flat;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [TW-1:0]          sum;
    logic                   fire;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = NREQ - 1;

    mcp_neuron_scheduler #(
        .NREQ(NREQ), .NIN(NIN), .WW(WW), .TW(TW), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .x_flat(x_flat), .w_flat(w_flat),
        .thresh_flat(thresh_flat), .gnt(gnt), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .fire(fire)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                rq;
        logic [NIN-1:0]    x;
        logic [NIN*WW-1:0] w;
        logic [TW-1:0]     th;
        logic [TW-1:0]     esum;
        logic              efire;
        bit                scr;
        string             nm;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain integer model: sum inputs one by one, clamping after each step.
    function automatic logic [TW:0] ref_eval(input logic [NIN-1:0] x,
                                             input logic [NIN*WW-1:0] w,
                                             input logic [TW-1:0] th);
        int acc = 0;
        int lo  = -(1 << (TW-1));
        int hi  = (1 << (TW-1)) - 1;
        logic signed [WW-1:0] wi;
        logic signed [TW-1:0] ts;
        for (int i = 0; i < NIN; i++) begin
            wi = w[i*WW +: WW];
            if (x[i]) acc += int'(wi);
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        ts = th;
        return {acc >= int'(ts), TW'(acc)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_data(input int r, input logic [NIN-1:0] x,
                            input logic [NIN*WW-1:0] w, input logic [TW-1:0] th);
        x_flat[r*NIN +: NIN]           = x;
        w_flat[r*NIN*WW +: NIN*WW]     = w;
        thresh_flat[r*TW +: TW]        = th;
    endtask

    task automatic run_eval(input logic [NREQ-1:0] mask, input int eid,
                            input logic [TW-1:0] esum, input logic efire,
                            input bit scr, input string nm);
        int n;
        int extra;
        @(negedge clk);
        req = mask;
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s gnt", nm), gnt, 32'(1 << eid));
        chk($sformatf("%s busy", nm), busy, 1);
        req = '0;
        if (scr) set_data(eid, ~x_flat[eid*NIN +: NIN], NIN*WW'($urandom), TW'($urandom));
        n = 0;
        extra = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (gnt != '0) extra++;
        end
        chk($sformatf("%s latency", nm), n, NIN + 1);
        chk($sformatf("%s extra_gnt", nm), extra, 0);
        chk($sformatf("%s done_id", nm), done_id, eid);
        chk($sformatf("%s sum", nm), sum, esum);
        chk($sformatf("%s fire", nm), fire, efire);
        chk($sformatf("%s busy_at_done", nm), busy, 0);
        @(negedge clk);
        chk($sformatf("%s done_pulse", nm), done, 0);
        m_ptr = eid;
    endtask

    initial begin
        logic [TW:0] r;
        logic [NREQ-1:0] mk;
        int win, ng, last, ovl, n, dcnt;

        tbl[0] = '{0, 4'b0000, 12'b000_000_000_111, 4'h0, 4'h0, 1'b1, 1'b0, "not_x0"};
        tbl[1] = '{0, 4'b0001, 12'b000_000_000_111, 4'h0, 4'hF, 1'b0, 1'b0, "not_x1"};
        tbl[2] = '{2, 4'b0000, 12'b000_000_001_001, 4'h2, 4'h0, 1'b0, 1'b0, "and_00"};
        tbl[3] = '{2, 4'b0001, 12'b000_000_001_001, 4'h2, 4'h1, 1'b0, 1'b0, "and_01"};
        tbl[4] = '{2, 4'b0010, 12'b000_000_001_001, 4'h2, 4'h1, 1'b0, 1'b0, "and_10"};
        tbl[5] = '{2, 4'b0011, 12'b000_000_001_001, 4'h2, 4'h2, 1'b1, 1'b0, "and_11"};
        tbl[6] = '{3, 4'b1111, 12'b011_011_011_011, 4'h7, 4'h7, 1'b1, 1'b0, "sat_pos"};
        tbl[7] = '{1, 4'b1111, 12'b100_100_100_100, 4'h8, 4'h8, 1'b1, 1'b0, "sat_neg"};
        tbl[8] = '{1, 4'b1010, 12'b001_000_010_000, 4'h3, 4'h3, 1'b1, 1'b1, "snapshot"};

        rst = 1'b1;
        req = '0;
        x_flat = '0;
        w_flat = '0;
        thresh_flat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst gnt", gnt, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst done_id", done_id, 0);
        chk("rst sum", sum, 0);
        chk("rst fire", fire, 0);

        for (int i = 0; i < 9; i++) begin
            set_data(tbl[i].rq, tbl[i].x, tbl[i].w, tbl[i].th);
            run_eval(NREQ'(1) << tbl[i].rq, tbl[i].rq, tbl[i].esum, tbl[i].efire,
                     tbl[i].scr, tbl[i].nm);
        end

        // Fairness: every requester held high through reset.
        @(negedge clk);
        rst = 1'b1;
        req = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = NREQ - 1;
        ng = 0;
        last = -1;
        ovl = 0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(negedge clk);
            if (gnt != '0 && done) ovl++;
            if (gnt != '0) begin
                win = rr_pick('1, m_ptr);
                chk($sformatf("rr grant%0d", ng), gnt, 32'(1 << win));
                if (last >= 0) chk($sformatf("rr spacing%0d", ng), c - last, NIN + 2);
                m_ptr = win;
                last = c;
                ng++;
            end
        end
        chk("rr grant_count", ng, 6);
        chk("rr overlap", ovl, 0);
        req = '0;
        repeat (NIN + 4) @(negedge clk);

        // Randomized multi-requester traffic against the model.
        for (int t = 0; t < 24; t++) begin
            for (int q = 0; q < NREQ; q++)
                set_data(q, NIN'($urandom), (NIN*WW)'($urandom), TW'($urandom));
            mk = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            win = rr_pick(mk, m_ptr);
            r = ref_eval(x_flat[win*NIN +: NIN], w_flat[win*NIN*WW +: NIN*WW],
                         thresh_flat[win*TW +: TW]);
            run_eval(mk, win, r[TW-1:0], r[TW], bit'($urandom & 1), $sformatf("rand%0d", t));
        end

        // Reset two edges after a grant aborts the evaluation.
        set_data(2, 4'b1111, 12'b011_011_011_011, 4'h7);
        run_eval(4'b0100, 2, 4'h7, 1'b1, 1'b0, "pre_abort");
        @(negedge clk);
        req = 4'b0100;
        n = 0;
        while (gnt == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort gnt", gnt, 32'b0100);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort sum", sum, 0);
        chk("abort fire", fire, 0);
        chk("abort busy", busy, 0);
        chk("abort done_id", done_id, 0);
        chk("abort gnt_low", gnt, 0);
        dcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort no_done", dcnt, 0);
        m_ptr = NREQ - 1;
        win = rr_pick('1, m_ptr);
        r = ref_eval(x_flat[win*NIN +: NIN], w_flat[win*NIN*WW +: NIN*WW],
                     thresh_flat[win*TW +: TW]);
        run_eval('1, win, r[TW-1:0], r[TW], 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcp_neuron_scheduler.md
Name: mcp_neuron_scheduler

Overview:
- Round-robin scheduler that time-shares one McCulloch-Pitts neuron evaluation datapath among NREQ requesters. Each requester supplies binary inputs, signed weights and a signed threshold.
- The block snapshots the granted request and accumulates the weighted sum serially, one input per cycle. It then compares the sum against the threshold and returns sum/fire with a one-cycle done strobe tagged with the requester id.
- It sits between gate-level neuron configurations (NOT/AND/OR style) and the shared threshold unit.

Parameters:
NREQ, 4, number of requesters (>=2)
NIN, 4, binary inputs per neuron evaluation
WW, 3, signed weight width
TW, 4, signed width of threshold, accumulator and sum output
IDW, 2, width of requester id (clog2(NREQ))

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req  in  NREQ  request per requester; level, held until granted
x_flat  in  NREQ*NIN  binary inputs; requester r at [r*NIN +: NIN], bit i = x[i]
w_flat  in  NREQ*NIN*WW  signed weights; requester r input i at [(r*NIN+i)*WW +: WW]
thresh_flat  in  NREQ*TW  signed thresholds; requester r at [r*TW +: TW]
gnt  out  NREQ  one-hot grant, one-cycle pulse
busy  out  1  high while an evaluation is in progress (states ACC, CMP)
done  out  1  one-cycle result strobe
done_id  out  IDW  requester id of the current result
sum  out  TW  signed saturated weighted sum of the last evaluation
fire  out  1  1 when sum >= threshold for the last evaluation

Behaviour:
- All outputs are registered. Reset (synchronous, rst=1 at an edge) forces: state IDLE, gnt=0, busy=0, done=0, done_id=0, sum=0, fire=0, accumulator=0, index=0, round-robin pointer=NREQ-1.
- FSM states: IDLE, ACC, CMP.
- IDLE, on an edge with req != 0:
  - Select the winner by searching from pointer+1 upward, wrapping at NREQ.
  - gnt <= onehot(winner); pointer <= winner.
  - Snapshot that requester's x, w and thresh.
  - acc <= 0, idx <= 0, busy <= 1, state <= ACC.
  - If req == 0, remain in IDLE with gnt=0.
- gnt is high only in the single cycle following the grant edge and is 0 in all other cycles.
- ACC, each edge:
  - acc <= sat(acc + (x[idx] ? sext(w[idx]) : 0)); idx <= idx+1.
  - On the edge where idx == NIN-1, state <= CMP.
- sat() clamps to [-2^(TW-1), 2^(TW-1)-1]. The addition is computed at TW+1 bits before clamping, and saturation applies at every step. A negative weight is a legal inhibitory input.
- CMP edge:
  - sum <= acc; fire <= (acc >= thresh), compared as signed.
  - done <= 1; done_id <= winner; busy <= 0; state <= IDLE.
- done is high for exactly one cycle. sum, fire and done_id hold their values until the next CMP edge or reset.
- Latency: the done cycle follows the grant edge by NIN+1 edges. Minimum spacing between grants is NIN+2 cycles, so gnt and done are never high in the same cycle.
- The snapshot is taken at grant, so requester inputs may change freely after their gnt pulse without affecting the result.
- Requests arriving during ACC or CMP are not sampled until the block returns to IDLE.
- A req deasserted before grant is dropped without error. A requester holding req after its grant is re-served only in round-robin order.
- Reset mid-evaluation aborts it: no done pulse, and sum/fire are cleared to 0.
- With NREQ requesters continuously asserting, each is served exactly once per NREQ grants.

Test Plan:
- NOT gate on requester 0: w0=-1, other weights 0, thresh=0, x0=0 -> done after NIN+1 edges, sum=0, fire=1, done_id=0. Then x0=1 -> sum=-1, fire=0.
- AND gate on requester 2: w0=w1=1, others 0, thresh=2. Inputs x=00/01/10/11 -> sum 0/1/1/2 and fire 0/0/0/1. gnt=4'b0100 pulses exactly once per request.
- Fairness: all four req held high from reset -> grant order 0,1,2,3,0,1. Grants are spaced NIN+2 cycles apart, and gnt never overlaps done.
- Saturation: all weights +3, x=1111, thresh=7 -> sum=7 (clamped from 12), fire=1. All weights -4, x=1111, thresh=-8 -> sum=-8, fire=1.
- Snapshot: change requester 1's x and w in the cycle after its gnt -> result matches the values present at grant.
- Reset mid-ACC: assert rst two edges after grant -> no done pulse, and all outputs read 0. The next request after reset is served by requester 0 first.
